mem_arbiter: RTL and testbench

//  Shares the single unified RAM port between instruction fetch (i-side) and the

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the unified RAM port between instruction fetch and data accesses.
// A data-grant streak limit keeps back-to-back data traffic from starving fetch.
module mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int TIMER_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t              state_reg, state_next;
  logic                ram_ren_reg, ram_ren_next;
  logic                ram_wen_reg, ram_wen_next;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0]   ram_store_reg, ram_store_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                err_reg, err_next;

  logic d_pend;
  logic streak_ok;
  logic timeout_hit;
  logic acc_end;

  assign d_pend      = dREN | dWEN;
  assign streak_ok   = (streak_reg < STREAK_W'(MAX_DATA_STREAK));
  assign timeout_hit = !ram_ready && (timer_reg == TIMER_W'(TIMEOUT - 1));
  assign acc_end     = ram_ready | timeout_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      ram_ren_reg   <= 1'b0;
      ram_wen_reg   <= 1'b0;
      ram_addr_reg  <= '0;
      ram_store_reg <= '0;
      streak_reg    <= '0;
      timer_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ram_ren_reg   <= ram_ren_next;
      ram_wen_reg   <= ram_wen_next;
      ram_addr_reg  <= ram_addr_next;
      ram_store_reg <= ram_store_next;
      streak_reg    <= streak_next;
      timer_reg     <= timer_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ram_ren_next   = ram_ren_reg;
    ram_wen_next   = ram_wen_reg;
    ram_addr_next  = ram_addr_reg;
    ram_store_next = ram_store_reg;
    streak_next    = streak_reg;
    timer_next     = timer_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (d_pend && (!iREN || streak_ok)) begin
          state_next    = DACC;
          ram_addr_next = daddr;
          // A write wins when both data strobes are high.
          if (dWEN) begin
            ram_wen_next   = 1'b1;
            ram_store_next = dstore;
          end else begin
            ram_ren_next = 1'b1;
          end
          if (streak_ok) begin
            streak_next = streak_reg + STREAK_W'(1);
          end
        end else if (iREN) begin
          state_next    = IACC;
          ram_addr_next = iaddr;
          ram_ren_next  = 1'b1;
          streak_next   = '0;
        end else begin
          streak_next = '0;
        end
      end
      IACC, DACC: begin
        if (acc_end) begin
          state_next   = IDLE;
          ram_ren_next = 1'b0;
          ram_wen_next = 1'b0;
          timer_next   = '0;
          if (timeout_hit) begin
            err_next = 1'b1;
          end
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        ram_ren_next = 1'b0;
        ram_wen_next = 1'b0;
      end
    endcase
  end

  // A requester that dropped its request mid-access gets no completion pulse.
  assign iwait = !((state_reg == IACC) && acc_end && iREN);
  assign dwait = !((state_reg == DACC) && acc_end && d_pend);

  assign iload    = ramload;
  assign dload    = ramload;
  assign ramREN   = ram_ren_reg;
  assign ramWEN   = ram_wen_reg;
  assign ramaddr  = ram_addr_reg;
  assign ramstore = ram_store_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the
// falling edge, so each step below corresponds to one clock cycle.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DATA_STREAK(4),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .dwait(dwait),
    .dload(dload),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ram_ready(ram_ready),
    .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, i.e. the middle of the next cycle.
  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;

    // Reset values
    nxt(); nxt(); #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_err", err, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    RST = 1'b0;

    // Instruction fetch, RAM ready on the second access cycle
    nxt(); iREN = 1'b1; iaddr = 32'h40; #1;
    chk("t1_idle_iwait", iwait, 1);
    nxt(); #1;
    chk("t1_ramREN", ramREN, 1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait_busy", iwait, 1);
    nxt(); ram_ready = 1'b1; ramload = 32'h1234_5678; #1;
    chk("t1_iwait_done", iwait, 0);
    chk("t1_iload", iload, 32'h1234_5678);
    chk("t1_dwait", dwait, 1);
    nxt(); ram_ready = 1'b0; iREN = 1'b0; #1;
    chk("t1_ramREN_clr", ramREN, 0);
    chk("t1_iwait_idle", iwait, 1);

    // Simultaneous data write and fetch: data first, then fetch
    nxt(); dWEN = 1'b1; iREN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD; iaddr = 32'h80; #1;
    chk("t2_idle_dwait", dwait, 1);
    nxt(); ram_ready = 1'b1; #1;
    chk("t2_ramWEN", ramWEN, 1);
    chk("t2_ramREN", ramREN, 0);
    chk("t2_ramaddr", ramaddr, 32'h100);
    chk("t2_ramstore", ramstore, 32'hDEAD);
    chk("t2_dwait_done", dwait, 0);
    chk("t2_iwait_hold", iwait, 1);
    nxt(); dWEN = 1'b0; ram_ready = 1'b0; #1;
    chk("t2_ramWEN_clr", ramWEN, 0);
    nxt(); ram_ready = 1'b1; #1;
    chk("t2_i_ramREN", ramREN, 1);
    chk("t2_i_ramaddr", ramaddr, 32'h80);
    chk("t2_i_iwait", iwait, 0);
    nxt(); iREN = 1'b0; ram_ready = 1'b0; #1;
    chk("t2_idle_ramREN", ramREN, 0);

    // Streak limit: both sides held, grant order d,d,d,d,i,d
    nxt(); dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h300; ram_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      nxt(); #1;
      chk($sformatf("t3_g%0d_ramaddr", g), ramaddr, (g == 4) ? 32'h300 : 32'h200);
      chk($sformatf("t3_g%0d_dwait", g), dwait, (g == 4) ? 1 : 0);
      chk($sformatf("t3_g%0d_iwait", g), iwait, (g == 4) ? 0 : 1);
      nxt(); #1;
      chk($sformatf("t3_g%0d_idle", g), ramREN, 0);
    end
    dREN = 1'b0; iREN = 1'b0; ram_ready = 1'b0;
    nxt();

    // Data read withdrawn mid-access: no completion pulse
    nxt(); dREN = 1'b1; daddr = 32'h400; #1;
    nxt(); dREN = 1'b0; #1;
    chk("t4_ramREN", ramREN, 1);
    chk("t4_ramaddr", ramaddr, 32'h400);
    chk("t4_dwait_busy", dwait, 1);
    nxt(); ram_ready = 1'b1; #1;
    chk("t4_dwait_dropped", dwait, 1);
    chk("t4_iwait", iwait, 1);
    nxt(); ram_ready = 1'b0; #1;
    chk("t4_ramREN_clr", ramREN, 0);

    // Timeout after 8 access cycles without ram_ready
    nxt(); dWEN = 1'b1; daddr = 32'h500; dstore = 32'hBEEF; #1;
    for (int k = 1; k <= 8; k++) begin
      nxt(); #1;
      chk($sformatf("t5_c%0d_ramWEN", k), ramWEN, 1);
      chk($sformatf("t5_c%0d_err", k), err, 0);
      chk($sformatf("t5_c%0d_dwait", k), dwait, (k == 8) ? 0 : 1);
    end
    nxt(); dWEN = 1'b0; #1;
    chk("t5_err_set", err, 1);
    chk("t5_ramWEN_drop", ramWEN, 0);
    nxt(); nxt(); #1;
    chk("t5_err_sticky", err, 1);

    // Reset in the middle of a fetch
    nxt(); iREN = 1'b1; iaddr = 32'h600; #1;
    nxt(); #1;
    chk("t6_ramREN", ramREN, 1);
    RST = 1'b1;
    nxt(); #1;
    chk("t6_ramREN_rst", ramREN, 0);
    chk("t6_err_rst", err, 0);
    chk("t6_ramaddr_rst", ramaddr, 0);
    chk("t6_iwait_rst", iwait, 1);
    RST = 1'b0;
    nxt(); ram_ready = 1'b1; #1;
    chk("t6_refetch_ramaddr", ramaddr, 32'h600);
    chk("t6_refetch_iwait", iwait, 0);
    nxt(); iREN = 1'b0; ram_ready = 1'b0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
